qpu_trace_buffer: RTL

QPU_TRACE_BUFFER -- requirements
Module: qpu_trace_buffer

---
 rtl/qpu_trace_buffer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/qpu_trace_buffer.sv
// Trace buffer for CPU/QPU state: samples periodically and/or on quantum_en rising edges into a
// first-word-fall-through FIFO, with either stop-when-full or overwrite-oldest behaviour.
module qpu_trace_buffer #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned SAMPLE_DIV = 5,
   parameter int unsigned WRAP       = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          stop,
   input  logic [1:0]    mode,
   input  logic [31:0]   pc,
   input  logic [31:0]   instr,
   input  logic          quantum_en,
   input  logic [1:0]    q_status,
   input  logic          q_busy,
   input  logic [31:0]   q_alpha,
   input  logic [31:0]   q_beta,
   input  logic          rd_ready,
   output logic          rd_valid,
   output logic [163:0]  rd_data,
   output logic [8:0]    count,
   output logic          running,
   output logic          full,
   output logic [15:0]   dropped
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned EW       = 164;
   localparam logic [8:0]  DepthCnt = 9'(DEPTH);
   localparam logic [15:0] DivLast  = 16'(SAMPLE_DIV - 1);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_e;

   state_e        state_q, state_d;
   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [8:0]    count_q, count_d;
   logic [15:0]   dropped_q, div_q;
   logic [31:0]   ts_q;
   logic          qen_prev_q;

   logic run, is_full, tick_hit, edge_hit, sample_sel, sample, pop, wr_en, drop, overwrite;

   always_comb begin
      run      = (state_q == StRun);
      is_full  = (count_q == DepthCnt);
      tick_hit = run && (div_q == DivLast);
      edge_hit = run && quantum_en && !qen_prev_q;
      case (mode)
         2'b01:   sample_sel = edge_hit;
         2'b10:   sample_sel = tick_hit || edge_hit;
         default: sample_sel = tick_hit;
      endcase
      // start wins over everything else in its cycle: no sample, no pop
      sample    = sample_sel && !start;
      pop       = (count_q != 9'd0) && rd_ready && !start;
      drop      = sample && is_full && !pop;
      overwrite = drop && (WRAP != 0);
      wr_en     = sample && (!is_full || pop || (WRAP != 0));
      count_d   = count_q;
      if (start) begin
         count_d = 9'd0;
      end else if (wr_en && !pop && !is_full) begin
         count_d = count_q + 9'd1;
      end else if (pop && !wr_en) begin
         count_d = count_q - 9'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StRun: begin
            if (start) begin
               state_d = StRun;
            end else if (stop) begin
               state_d = StHalt;
            end else if ((WRAP == 0) && (count_d == DepthCnt)) begin
               state_d = StHalt;
            end
         end
         default: begin
            if (start) begin
               state_d = StRun;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         count_q    <= 9'd0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         dropped_q  <= 16'd0;
         ts_q       <= 32'd0;
         div_q      <= 16'd0;
         qen_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         qen_prev_q <= quantum_en;
         if (start) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            dropped_q <= 16'd0;
            ts_q      <= 32'd0;
            div_q     <= 16'd0;
         end else begin
            if (wr_en) begin
               wptr_q <= wptr_q + 1'b1;
            end
            if (pop || overwrite) begin
               rptr_q <= rptr_q + 1'b1;
            end
            if (drop && (dropped_q != 16'hFFFF)) begin
               dropped_q <= dropped_q + 16'd1;
            end
            if (run) begin
               ts_q  <= ts_q + 32'd1;
               div_q <= tick_hit ? 16'd0 : div_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wptr_q] <= {ts_q, pc, instr, q_alpha, q_beta, q_status, quantum_en, q_busy};
      end
   end

   assign rd_valid = (count_q != 9'd0);
   assign rd_data  = rd_valid ? mem_q[rptr_q] : '0;
   assign count    = count_q;
   assign running  = run;
   assign full     = is_full;
   assign dropped  = dropped_q;

endmodule
